// File: rtl/rst_seq_if.sv
// Soft-reset handshake and sequenced reset/enable outputs of rst_seq_ctrl.
// The master side requests soft resets and observes the sequence; the controller is the slave.
interface rst_seq_if #(
    parameter int N_BLK = 4
);
    logic             soft_rst_req;
    logic             soft_rst_ack;
    logic [N_BLK-1:0] blk_rst_n;
    logic             cnt_en;
    logic             ready;

    modport master (
        output soft_rst_req,
        input  soft_rst_ack,
        input  blk_rst_n,
        input  cnt_en,
        input  ready
    );

    modport slave (
        input  soft_rst_req,
        output soft_rst_ack,
        output blk_rst_n,
        output cnt_en,
        output ready
    );
endinterface

// File: rtl/rst_seq_ctrl.sv
// Reset/enable sequencer for the Gray counter datapath: synchronizes rst_n release,
// releases sub-block resets in order, then enables counting; soft requests replay it.
//
//  state     | meaning
//  ----------+-----------------------------------------------------------
//  S_SYNC    | waiting for the rst_n deassertion synchronizer to fill
//  S_HOLD    | all blk_rst_n low for HOLD_CYC cycles
//  S_RELEASE | releasing blk_rst_n bits one at a time, REL_GAP apart
//  S_RUN     | sequence complete, cnt_en/ready high, soft requests served
module rst_seq_ctrl #(
    parameter int N_BLK       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYC    = 4,
    parameter int REL_GAP     = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    rst_seq_if.slave     bus
);
    localparam int MX = (HOLD_CYC > REL_GAP) ? HOLD_CYC : REL_GAP;
    localparam int CW = $clog2(MX + 1);
    localparam int IW = $clog2(N_BLK + 1);
    // The state register's exit from S_SYNC acts as the final synchronizer stage.
    localparam int SW = SYNC_STAGES - 1;

    typedef enum logic [1:0] {
        S_SYNC    = 2'd0,
        S_HOLD    = 2'd1,
        S_RELEASE = 2'd2,
        S_RUN     = 2'd3
    } state_t;

    state_t        state;
    logic [SW-1:0] sync_q;
    logic [CW-1:0] cnt;
    logic [IW-1:0] idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= S_SYNC;
            sync_q           <= '0;
            cnt              <= '0;
            idx              <= '0;
            bus.blk_rst_n    <= '0;
            bus.cnt_en       <= 1'b0;
            bus.ready        <= 1'b0;
            bus.soft_rst_ack <= 1'b0;
        end else begin
            sync_q <= (sync_q << 1) | SW'(1);
            if (!bus.soft_rst_req) begin
                bus.soft_rst_ack <= 1'b0;
            end
            case (state)
                S_SYNC: begin
                    if (sync_q[SW-1]) begin
                        state <= S_HOLD;
                        cnt   <= '0;
                        idx   <= '0;
                    end
                end
                S_HOLD: begin
                    if (cnt == CW'(HOLD_CYC - 1)) begin
                        state         <= S_RELEASE;
                        cnt           <= '0;
                        idx           <= IW'(1);
                        bus.blk_rst_n <= (bus.blk_rst_n << 1) | N_BLK'(1);
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_RELEASE: begin
                    if (idx == IW'(N_BLK)) begin
                        state            <= S_RUN;
                        cnt              <= '0;
                        bus.cnt_en       <= 1'b1;
                        bus.ready        <= 1'b1;
                        // A request still pending at completion is acked, never replayed.
                        bus.soft_rst_ack <= bus.soft_rst_req;
                    end else if (cnt == CW'(REL_GAP - 1)) begin
                        cnt           <= '0;
                        idx           <= idx + IW'(1);
                        bus.blk_rst_n <= (bus.blk_rst_n << 1) | N_BLK'(1);
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_RUN: begin
                    if (bus.soft_rst_req && !bus.soft_rst_ack) begin
                        state         <= S_HOLD;
                        cnt           <= '0;
                        idx           <= '0;
                        bus.blk_rst_n <= '0;
                        bus.cnt_en    <= 1'b0;
                        bus.ready     <= 1'b0;
                    end
                end
                default: state <= S_SYNC;
            endcase
        end
    end
endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Directed bench for rst_seq_ctrl: default instance plus a minimal N_BLK=1 instance.
module tb_rst_seq_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    rst_seq_if #(.N_BLK(4)) bus  ();
    rst_seq_if #(.N_BLK(1)) bus6 ();

    rst_seq_ctrl #(.N_BLK(4), .SYNC_STAGES(2), .HOLD_CYC(4), .REL_GAP(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    rst_seq_ctrl #(.N_BLK(1), .SYNC_STAGES(2), .HOLD_CYC(1), .REL_GAP(1)) dut6 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus6.slave)
    );

    // Released bits for the default parameters, t = edges since HOLD entry.
    function automatic logic [3:0] exp_blk(input int t);
        if (t < 4)       return 4'b0000;
        else if (t < 7)  return 4'b0001;
        else if (t < 10) return 4'b0011;
        else if (t < 13) return 4'b0111;
        else             return 4'b1111;
    endfunction

    task automatic por();
        rst_n = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Steps edges first_e..last_e; HOLD was entered on edge h.
    task automatic run_seq(input string nm, input int first_e, input int last_e, input int h,
                           input int req_on_e, input int req_off_e, input logic ack_run,
                           input bit chk6);
        logic [3:0] eb;
        logic       er, ea;
        for (int e = first_e; e <= last_e; e++) begin
            @(posedge clk);
            #1;
            eb = exp_blk(e - h);
            er = ((e - h) >= 14);
            ea = er ? ack_run : 1'b0;
            n_cmp += 4;
            if (bus.blk_rst_n !== eb) begin
                n_bad++;
                $display("FAIL %s blk_rst_n edge %0d: got %b want %b", nm, e, bus.blk_rst_n, eb);
            end
            if (bus.ready !== er) begin
                n_bad++;
                $display("FAIL %s ready edge %0d: got %b want %b", nm, e, bus.ready, er);
            end
            if (bus.cnt_en !== er) begin
                n_bad++;
                $display("FAIL %s cnt_en edge %0d: got %b want %b", nm, e, bus.cnt_en, er);
            end
            if (bus.soft_rst_ack !== ea) begin
                n_bad++;
                $display("FAIL %s ack edge %0d: got %b want %b", nm, e, bus.soft_rst_ack, ea);
            end
            if (chk6) begin
                n_cmp += 3;
                if (bus6.blk_rst_n !== (e >= 3)) begin
                    n_bad++;
                    $display("FAIL n1 blk_rst_n edge %0d: got %b want %b", e, bus6.blk_rst_n, (e >= 3));
                end
                if (bus6.ready !== (e >= 4)) begin
                    n_bad++;
                    $display("FAIL n1 ready edge %0d: got %b want %b", e, bus6.ready, (e >= 4));
                end
                if (bus6.cnt_en !== (e >= 4)) begin
                    n_bad++;
                    $display("FAIL n1 cnt_en edge %0d: got %b want %b", e, bus6.cnt_en, (e >= 4));
                end
            end
            if (e == req_on_e)  bus.soft_rst_req = 1'b1;
            if (e == req_off_e) bus.soft_rst_req = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp += 5;
        if (bus.blk_rst_n !== 4'b0000) begin n_bad++; $display("FAIL reset blk_rst_n: got %b want 0000", bus.blk_rst_n); end
        if (bus.ready !== 1'b0)        begin n_bad++; $display("FAIL reset ready: got %b want 0", bus.ready); end
        if (bus.cnt_en !== 1'b0)       begin n_bad++; $display("FAIL reset cnt_en: got %b want 0", bus.cnt_en); end
        if (bus.soft_rst_ack !== 1'b0) begin n_bad++; $display("FAIL reset ack: got %b want 0", bus.soft_rst_ack); end
        if (bus6.blk_rst_n !== 1'b0)   begin n_bad++; $display("FAIL reset n1 blk_rst_n: got %b want 0", bus6.blk_rst_n); end
    endtask

    task automatic test_power_on();
        por();
        run_seq("por", 1, 18, 2, -1, -1, 1'b0, 1'b1);
    endtask

    task automatic test_rst_pulse();
        por();
        run_seq("pulse_pre", 1, 10, 2, -1, -1, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        n_cmp += 3;
        if (bus.blk_rst_n !== 4'b0000) begin n_bad++; $display("FAIL pulse async blk_rst_n: got %b want 0000", bus.blk_rst_n); end
        if (bus.ready !== 1'b0)        begin n_bad++; $display("FAIL pulse async ready: got %b want 0", bus.ready); end
        if (bus.cnt_en !== 1'b0)       begin n_bad++; $display("FAIL pulse async cnt_en: got %b want 0", bus.cnt_en); end
        #2;
        rst_n = 1'b1;
        run_seq("pulse_post", 1, 17, 2, -1, -1, 1'b0, 1'b0);
    endtask

    task automatic test_soft();
        por();
        run_seq("soft_pre", 1, 18, 2, -1, -1, 1'b0, 1'b0);
        bus.soft_rst_req = 1'b1;
        run_seq("soft", 0, 15, 0, -1, -1, 1'b1, 1'b0);
        bus.soft_rst_req = 1'b0;
        @(posedge clk);
        #1;
        n_cmp += 2;
        if (bus.soft_rst_ack !== 1'b0) begin n_bad++; $display("FAIL soft ack_drop: got %b want 0", bus.soft_rst_ack); end
        if (bus.ready !== 1'b1)        begin n_bad++; $display("FAIL soft ready_hold: got %b want 1", bus.ready); end
    endtask

    task automatic test_req_through_por();
        bus.soft_rst_req = 1'b1;
        por();
        run_seq("por_req", 1, 22, 2, -1, -1, 1'b1, 1'b0);
        bus.soft_rst_req = 1'b0;
        @(posedge clk);
        #1;
        n_cmp += 2;
        if (bus.soft_rst_ack !== 1'b0)   begin n_bad++; $display("FAIL por_req ack_drop: got %b want 0", bus.soft_rst_ack); end
        if (bus.blk_rst_n !== 4'b1111)   begin n_bad++; $display("FAIL por_req blk_hold: got %b want 1111", bus.blk_rst_n); end
        bus.soft_rst_req = 1'b1;
        run_seq("replay", 0, 15, 0, -1, -1, 1'b1, 1'b0);
        bus.soft_rst_req = 1'b0;
    endtask

    task automatic test_req_in_release();
        por();
        run_seq("rel_drop", 1, 18, 2, 8, 12, 1'b0, 1'b0);
        por();
        run_seq("rel_hold", 1, 18, 2, 10, -1, 1'b1, 1'b0);
        bus.soft_rst_req = 1'b0;
    endtask

    initial begin
        bus.soft_rst_req  = 1'b0;
        bus6.soft_rst_req = 1'b0;
        test_reset();
        test_power_on();
        test_rst_pulse();
        test_soft();
        test_req_through_por();
        test_req_in_release();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
